// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between the CPU and a debug/loader port.
// Ports: iClk/iRst (sync active-high); CPU side iCpu_Read/iCpu_Write/iCpu_Addr/iCpu_WData -> oCpu_RData/oCpu_Rdy;
// debug side iDbg_Req/iDbg_We/iDbg_Addr/iDbg_WData -> oDbg_Gnt/oDbg_Done/oDbg_RData;
// memory side oMem_Addr/oMem_WData/oMem_Read/oMem_Write <- iMem_RData (valid in the last access cycle).
module mem_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCpu_Read,
  input  logic        iCpu_Write,
  input  logic [31:0] iCpu_Addr,
  input  logic [31:0] iCpu_WData,
  output logic [31:0] oCpu_RData,
  output logic        oCpu_Rdy,
  input  logic        iDbg_Req,
  input  logic        iDbg_We,
  input  logic [31:0] iDbg_Addr,
  input  logic [31:0] iDbg_WData,
  output logic        oDbg_Gnt,
  output logic        oDbg_Done,
  output logic [31:0] oDbg_RData,
  output logic [31:0] oMem_Addr,
  output logic [31:0] oMem_WData,
  output logic        oMem_Read,
  output logic        oMem_Write,
  input  logic [31:0] iMem_RData
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CPU_ACC  = 3'd1;
  localparam logic [2:0] DBG_ACC  = 3'd2;
  localparam logic [2:0] CPU_DONE = 3'd3;
  localparam logic [2:0] DBG_DONE = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_dbg_q, last_dbg_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        cpu_req, grant_dbg, acc, last;
  assign cpu_req   = iCpu_Read | iCpu_Write;
  // debug wins when alone, or on a tie when the CPU was granted last
  assign grant_dbg = iDbg_Req & (~cpu_req | ~last_dbg_q);
  assign acc       = (state_q == CPU_ACC) | (state_q == DBG_ACC);
  assign last      = acc & (cnt_q == 4'd0);
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dbg_d  = last_dbg_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    if (state_q == IDLE && (cpu_req | iDbg_Req)) begin
      state_d    = grant_dbg ? DBG_ACC : CPU_ACC;
      cnt_d      = 4'(MEM_LATENCY - 1);
      last_dbg_d = grant_dbg;
      addr_d     = grant_dbg ? iDbg_Addr : iCpu_Addr;
      wdata_d    = grant_dbg ? iDbg_WData : iCpu_WData;
      we_d       = grant_dbg ? iDbg_We : iCpu_Write;
    end else if (acc) begin
      cnt_d       = last ? 4'd0 : cnt_q - 4'd1;
      state_d     = !last ? state_q : (state_q == CPU_ACC) ? CPU_DONE : DBG_DONE;
      cpu_rdata_d = (last & ~we_q & (state_q == CPU_ACC)) ? iMem_RData : cpu_rdata_q;
      dbg_rdata_d = (last & ~we_q & (state_q == DBG_ACC)) ? iMem_RData : dbg_rdata_q;
    end else if (state_q == CPU_DONE || state_q == DBG_DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_dbg_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dbg_q  <= last_dbg_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
  // every output is forced low while reset is held, even before the first reset edge
  assign oMem_Read  = ~iRst & acc & ~we_q;
  assign oMem_Write = ~iRst & acc & we_q;
  assign oMem_Addr  = (~iRst & acc) ? addr_q : '0;
  assign oMem_WData = (~iRst & acc) ? wdata_q : '0;
  assign oCpu_Rdy   = ~iRst & ((state_q == CPU_DONE) | ~cpu_req);
  assign oCpu_RData = iRst ? '0 : cpu_rdata_q;
  assign oDbg_Gnt   = ~iRst & ((state_q == DBG_ACC) | (state_q == DBG_DONE));
  assign oDbg_Done  = ~iRst & (state_q == DBG_DONE);
  assign oDbg_RData = iRst ? '0 : dbg_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: checks two arbiters (latency 2 and 1) against a timeline model plus directed literal checks.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, cpu_read, cpu_write, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic [31:0] cpu_rdata[2], dbg_rdata[2], mem_addr[2], mem_wdata[2];
  logic cpu_rdy[2], dbg_gnt[2], dbg_done[2], mem_read[2], mem_write[2];
  int vectors = 0;
  int errors = 0;
  mem_arbiter #(.MEM_LATENCY(2)) u_a (
    .iClk(clk), .iRst(rst), .iCpu_Read(cpu_read), .iCpu_Write(cpu_write),
    .iCpu_Addr(cpu_addr), .iCpu_WData(cpu_wdata), .oCpu_RData(cpu_rdata[0]), .oCpu_Rdy(cpu_rdy[0]),
    .iDbg_Req(dbg_req), .iDbg_We(dbg_we), .iDbg_Addr(dbg_addr), .iDbg_WData(dbg_wdata),
    .oDbg_Gnt(dbg_gnt[0]), .oDbg_Done(dbg_done[0]), .oDbg_RData(dbg_rdata[0]),
    .oMem_Addr(mem_addr[0]), .oMem_WData(mem_wdata[0]), .oMem_Read(mem_read[0]),
    .oMem_Write(mem_write[0]), .iMem_RData(mem_rdata));
  mem_arbiter #(.MEM_LATENCY(1)) u_b (
    .iClk(clk), .iRst(rst), .iCpu_Read(cpu_read), .iCpu_Write(cpu_write),
    .iCpu_Addr(cpu_addr), .iCpu_WData(cpu_wdata), .oCpu_RData(cpu_rdata[1]), .oCpu_Rdy(cpu_rdy[1]),
    .iDbg_Req(dbg_req), .iDbg_We(dbg_we), .iDbg_Addr(dbg_addr), .iDbg_WData(dbg_wdata),
    .oDbg_Gnt(dbg_gnt[1]), .oDbg_Done(dbg_done[1]), .oDbg_RData(dbg_rdata[1]),
    .oMem_Addr(mem_addr[1]), .oMem_WData(mem_wdata[1]), .oMem_Read(mem_read[1]),
    .oMem_Write(mem_write[1]), .iMem_RData(mem_rdata));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Timeline model: owner 0=none 1=cpu 2=dbg; an access granted in idle cycle t0
  // strobes in t0+1..t0+L, completes in t0+L+1, and the arbiter is idle again after that.
  int cyc = 0;
  bit armed = 0;
  int owner[2] = '{0, 0};
  int t0[2] = '{0, 0};
  bit we_m[2], last_dbg[2];
  logic [31:0] addr_m[2], wd_m[2], crd[2], drd[2];
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int k, l;
      bit acc, dn, creq, g;
      string s;
      l = (i == 0) ? 2 : 1;
      k = cyc - t0[i];
      acc = owner[i] != 0 && k >= 1 && k <= l;
      dn = owner[i] != 0 && k == l + 1;
      creq = cpu_read | cpu_write;
      s = $sformatf("[%0d]", i);
      if (armed) begin
        chk({"mem_read", s}, 32'(mem_read[i]), 32'(!rst && acc && !we_m[i]));
        chk({"mem_write", s}, 32'(mem_write[i]), 32'(!rst && acc && we_m[i]));
        chk({"mem_addr", s}, mem_addr[i], (!rst && acc) ? addr_m[i] : 32'h0);
        chk({"mem_wdata", s}, mem_wdata[i], (!rst && acc) ? wd_m[i] : 32'h0);
        chk({"cpu_rdy", s}, 32'(cpu_rdy[i]), 32'(!rst && ((owner[i] == 1 && dn) || !creq)));
        chk({"dbg_gnt", s}, 32'(dbg_gnt[i]), 32'(!rst && owner[i] == 2 && (acc || dn)));
        chk({"dbg_done", s}, 32'(dbg_done[i]), 32'(!rst && owner[i] == 2 && dn));
        chk({"cpu_rdata", s}, cpu_rdata[i], rst ? 32'h0 : crd[i]);
        chk({"dbg_rdata", s}, dbg_rdata[i], rst ? 32'h0 : drd[i]);
      end
      if (rst) begin
        owner[i] = 0;
        last_dbg[i] = 1;
        crd[i] = 0;
        drd[i] = 0;
        addr_m[i] = 0;
        wd_m[i] = 0;
        we_m[i] = 0;
        armed = 1;
      end else begin
        if (owner[i] != 0 && k == l && !we_m[i]) begin
          if (owner[i] == 1) crd[i] = mem_rdata;
          else drd[i] = mem_rdata;
        end
        if (owner[i] != 0 && k == l + 1) owner[i] = 0;
        else if (owner[i] == 0 && (creq || dbg_req)) begin
          g = dbg_req && (!creq || !last_dbg[i]);
          owner[i] = g ? 2 : 1;
          t0[i] = cyc;
          we_m[i] = g ? dbg_we : cpu_write;
          addr_m[i] = g ? dbg_addr : cpu_addr;
          wd_m[i] = g ? dbg_wdata : cpu_wdata;
          last_dbg[i] = g;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    cpu_read = 0; cpu_write = 0; dbg_req = 0; dbg_we = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask
  initial begin
    rst = 1; clr();
    cpu_addr = 0; cpu_wdata = 0; dbg_addr = 0; dbg_wdata = 0; mem_rdata = 0;
    @(negedge clk);
    chk("rst_rdy", 32'(cpu_rdy[0]), 0);
    chk("rst_read", 32'(mem_read[0]), 0);
    chk("rst_gnt", 32'(dbg_gnt[0]), 0);
    tick();
    rst = 0;
    // CPU read of 0x10
    cpu_read = 1; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    @(negedge clk); chk("r_c0_rdy", 32'(cpu_rdy[0]), 0);
    tick(); @(negedge clk); chk("r_c1_read", 32'(mem_read[0]), 1); chk("r_c1_addr", mem_addr[0], 32'h10);
    tick(); @(negedge clk); chk("r_c2_read", 32'(mem_read[0]), 1);
    tick(); @(negedge clk); chk("r_c3_rdy", 32'(cpu_rdy[0]), 1); chk("r_c3_read", 32'(mem_read[0]), 0);
    chk("r_c3_rdata", cpu_rdata[0], 32'hDEADBEEF);
    tick(); cpu_read = 0;
    @(negedge clk); chk("r_c4_rdy", 32'(cpu_rdy[0]), 1);
    repeat (6) tick();
    // CPU write and debug read together right after reset
    do_reset();
    cpu_write = 1; cpu_addr = 32'h40; cpu_wdata = 32'h12345678;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h80; mem_rdata = 32'h0BADF00D;
    tick(); @(negedge clk); chk("t_c1_write", 32'(mem_write[0]), 1); chk("t_c1_gnt", 32'(dbg_gnt[0]), 0);
    chk("t_c1_wdata", mem_wdata[0], 32'h12345678);
    tick(); tick(); @(negedge clk); chk("t_c3_rdy", 32'(cpu_rdy[0]), 1); chk("t_c3_done", 32'(dbg_done[0]), 0);
    tick(); cpu_write = 0;
    tick(); @(negedge clk); chk("t_c5_gnt", 32'(dbg_gnt[0]), 1); chk("t_c5_addr", mem_addr[0], 32'h80);
    tick(); tick(); @(negedge clk); chk("t_c7_done", 32'(dbg_done[0]), 1);
    chk("t_c7_rdata", dbg_rdata[0], 32'h0BADF00D); chk("t_c7_cpu_rdata", cpu_rdata[0], 32'h0);
    tick(); dbg_req = 0;
    repeat (6) tick();
    // both requesters held: strict alternation CPU, DBG, CPU, DBG
    cpu_read = 1; dbg_req = 1; dbg_we = 1; dbg_wdata = 32'hA5A5A5A5; mem_rdata = 32'h77;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c % 4 == 1) begin
        chk($sformatf("alt_gnt_c%0d", c), 32'(dbg_gnt[0]), 32'((c / 4) % 2));
        chk($sformatf("alt_strobe_c%0d", c), 32'(mem_read[0] | mem_write[0]), 1);
      end
      tick();
    end
    clr();
    repeat (6) tick();
    // latency-1 debug write
    do_reset();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h55; mem_rdata = 32'hCAFEF00D;
    tick(); dbg_req = 0;
    @(negedge clk); chk("w1_c1_write", 32'(mem_write[1]), 1); chk("w1_c1_addr", mem_addr[1], 32'h20);
    chk("w1_c1_wdata", mem_wdata[1], 32'h55);
    tick(); @(negedge clk); chk("w1_c2_write", 32'(mem_write[1]), 0); chk("w1_c2_done", 32'(dbg_done[1]), 1);
    chk("w1_c2_rdata", dbg_rdata[1], 32'h0);
    tick(); @(negedge clk); chk("w1_c3_done", 32'(dbg_done[1]), 0);
    repeat (4) tick();
    // reset in the second CPU access cycle
    do_reset();
    cpu_read = 1; cpu_addr = 32'h30; mem_rdata = 32'h11112222;
    tick(); tick(); rst = 1;
    @(negedge clk); chk("ra_c2_read", 32'(mem_read[0]), 0); chk("ra_c2_rdy", 32'(cpu_rdy[0]), 0);
    chk("ra_c2_addr", mem_addr[0], 32'h0);
    tick(); rst = 0;
    @(negedge clk); chk("ra_c3_read", 32'(mem_read[0]), 0); chk("ra_c3_rdy", 32'(cpu_rdy[0]), 0);
    tick(); @(negedge clk); chk("ra_c4_read", 32'(mem_read[0]), 1);
    tick(); tick(); @(negedge clk); chk("ra_c6_rdy", 32'(cpu_rdy[0]), 1);
    chk("ra_c6_rdata", cpu_rdata[0], 32'h11112222);
    tick(); clr();
    repeat (4) tick();
    // debug access with no CPU request: ready stays high
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h44; mem_rdata = 32'h9;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("idle_rdy_c%0d", c), 32'(cpu_rdy[0]), 1);
      tick();
      dbg_req = 0;
    end
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LATENCY, 2, access cycles per memory transfer; legal range 1..15.
REQ-002 iClk  in  1  sole clock; all state updates on rising edge.
REQ-003 iRst  in  1  reset; synchronous, active-high.
REQ-004 iCpu_Read  in  1  CPU read request level; driven by control unit oMemRead.
REQ-005 iCpu_Write  in  1  CPU write request level; driven by control unit oMemWrite.
REQ-006 iCpu_Addr  in  32  CPU address.
REQ-007 iCpu_WData  in  32  CPU write data.
REQ-008 oCpu_RData  out  32  CPU read data, registered and held.
REQ-009 oCpu_Rdy  out  1  step-advance enable to control unit iRdy.
REQ-010 iDbg_Req  in  1  debug/loader request level.
REQ-011 iDbg_We  in  1  debug direction: 1 = write, 0 = read.
REQ-012 iDbg_Addr  in  32  debug address.
REQ-013 iDbg_WData  in  32  debug write data.
REQ-014 oDbg_Gnt  out  1  debug port owns memory.
REQ-015 oDbg_Done  out  1  one-cycle debug completion pulse.
REQ-016 oDbg_RData  out  32  debug read data, registered and held.
REQ-017 oMem_Addr  out  32  memory address.
REQ-018 oMem_WData  out  32  memory write data.
REQ-019 oMem_Read  out  1  memory read strobe.
REQ-020 oMem_Write  out  1  memory write strobe.
REQ-021 iMem_RData  in  32  memory read data; valid in the last access cycle.

Function
REQ-022 States SHALL be: IDLE, CPU_ACC, DBG_ACC, CPU_DONE, DBG_DONE.
REQ-023 CPU request = iCpu_Read | iCpu_Write; if both are high, the access SHALL be a write.
REQ-024 From IDLE with one request pending, go to the matching ACC state next cycle.
REQ-025 From IDLE with both requests pending, grant the requester not granted last (round-robin); the last-grant flag SHALL update on each grant.
REQ-026 On leaving IDLE, latch address, write data and direction; load down-counter with MEM_LATENCY-1.
REQ-027 In ACC states: drive oMem_Addr/oMem_WData from the latched values; assert exactly one of oMem_Read/oMem_Write per latched direction; decrement the counter each cycle.
REQ-028 ACC with counter == 0 SHALL go to DONE next cycle and capture iMem_RData into the owner's RData register (reads only; writes leave the register unchanged).
REQ-029 Outside ACC states: oMem_Read = oMem_Write = 0 and oMem_Addr = oMem_WData = 0.
REQ-030 CPU_DONE: oCpu_Rdy = 1 for exactly one cycle, then IDLE.
REQ-031 DBG_DONE: oDbg_Done = 1 for exactly one cycle, then IDLE.
REQ-032 oCpu_Rdy SHALL be 1 whenever there is no CPU request and the block is not in reset, regardless of debug activity; it SHALL be 0 while a CPU request is pending and not in CPU_DONE.
REQ-033 oDbg_Gnt SHALL be 1 in DBG_ACC and DBG_DONE only.
REQ-034 Latency, request seen in IDLE at cycle t: strobes in t+1..t+MEM_LATENCY, DONE at t+MEM_LATENCY+1, IDLE at t+MEM_LATENCY+2.
REQ-035 A request level present in the cycle after DONE SHALL be treated as a new request.
REQ-036 Request deasserted mid-access: the access SHALL complete unchanged, with DONE asserted as normal.
REQ-037 Requests arriving in non-IDLE states SHALL wait; no request is dropped, and at most one access is in flight.

Reset
REQ-038 iRst high at a rising edge SHALL force: IDLE state, counter 0, last-grant = debug (so the CPU wins the first tie), RData registers 0, latched address/data 0.
REQ-039 While iRst is high, all outputs SHALL be 0, including oCpu_Rdy; reset during an access SHALL abort it with no DONE pulse.

Verification
REQ-040 CPU read of 0x10, iMem_RData = 0xDEADBEEF -> oMem_Read high for cycles 1-2, oCpu_Rdy pulse at cycle 3, oCpu_RData = 0xDEADBEEF.
REQ-041 CPU write and debug read requested together after reset -> CPU served first, debug next; oDbg_Done 4 cycles after oCpu_Rdy.
REQ-042 Both requesters held continuously -> grants strictly alternate CPU, DBG, CPU, DBG.
REQ-043 MEM_LATENCY = 1, debug write of 0x55 to 0x20 -> oMem_Write for exactly 1 cycle, oDbg_Done next cycle, oDbg_RData unchanged.
REQ-044 iRst asserted in the 2nd CPU_ACC cycle -> next cycle all outputs 0, no oCpu_Rdy pulse; a fresh request then completes normally.
REQ-045 No CPU request while debug access in progress -> oCpu_Rdy stays 1 throughout.
